// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: arbiter state encoding, frame field constants and
// the frame validity check used when a transaction is granted.
package mdio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;

    function automatic logic frame_valid(input logic [31:0] frame);
        logic start_ok;
        logic op_ok;
        start_ok = (frame[31:30] == START);
        op_ok    = (frame[29:28] == OP_WR) || (frame[29:28] == OP_RD);
        return start_ok && op_ok;
    endfunction

    function automatic logic frame_is_read(input logic [31:0] frame);
        return (frame[29:28] == OP_RD);
    endfunction

endpackage

// File: rtl/mdio_rr_pick.sv
// Two-way round-robin choice: on a tie the requester that was not granted
// last wins; a lone request wins outright.
module mdio_rr_pick
    import mdio_pkg::*;
(
    input  logic REQ0,
    input  logic REQ1,
    input  logic LAST,
    output logic WINNER
);

    // Winner selection; with no request the pointer is passed through unchanged
    always_comb begin
        WINNER = LAST;
        case ({REQ1, REQ0})
            2'b11:   WINNER = ~LAST;
            2'b01:   WINNER = 1'b0;
            2'b10:   WINNER = 1'b1;
            default: WINNER = LAST;
        endcase
    end

endmodule

// File: rtl/mdio_arbiter.sv
// Arbitrates two requesters onto one MDIO transmitter: round-robin grant,
// frame validation, completion/timeout handling and per-requester read data.
module mdio_arbiter
    import mdio_pkg::*;
#(
    parameter int unsigned TIMEOUT = 100
) (
    input  logic        MDC,
    input  logic        RESET,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic [31:0] FRAME0,
    input  logic [31:0] FRAME1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        DONE0,
    output logic        DONE1,
    output logic        ERR0,
    output logic        ERR1,
    output logic [15:0] RDATA0,
    output logic [15:0] RDATA1,
    output logic        MDIO_START,
    output logic [31:0] T_DATA,
    input  logic        MDIO_DONE,
    input  logic [15:0] RD_DATA
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e      state_r;
    state_e      state_s;
    logic        last_r;
    logic        last_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_s;
    logic [7:0]  cnt_inc_s;
    logic        timeout_hit_s;
    logic        any_req_s;
    logic        winner_s;
    logic [31:0] pick_frame_s;
    logic        pick_valid_s;
    logic [31:0] t_data_r;
    logic [31:0] t_data_s;
    logic        gnt0_r, gnt1_r, gnt0_s, gnt1_s;
    logic        done0_r, done1_r, done0_s, done1_s;
    logic        err0_r, err1_r, err0_s, err1_s;
    logic        start_r, start_s;
    logic [15:0] rdata0_r, rdata1_r, rdata0_s, rdata1_s;

    mdio_rr_pick u_pick (
        .REQ0   (REQ0),
        .REQ1   (REQ1),
        .LAST   (last_r),
        .WINNER (winner_s)
    );

    assign any_req_s     = REQ0 | REQ1;
    assign pick_frame_s  = winner_s ? FRAME1 : FRAME0;
    assign pick_valid_s  = frame_valid(pick_frame_s);
    // Counter holds completed silent BUSY cycles; abort once this cycle reaches TIMEOUT
    assign cnt_inc_s     = cnt_r + 8'd1;
    assign timeout_hit_s = (cnt_inc_s == TIMEOUT_C);

    // State register
    always_ff @(posedge MDC or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; completion outranks timeout
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s = pick_valid_s ? ST_BUSY : ST_ERR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (MDIO_DONE) begin
                    state_s = ST_DONE;
                end else if (timeout_hit_s) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            ST_ERR:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        last_s   = last_r;
        cnt_s    = cnt_r;
        t_data_s = t_data_r;
        gnt0_s   = gnt0_r;
        gnt1_s   = gnt1_r;
        done0_s  = 1'b0;
        done1_s  = 1'b0;
        err0_s   = 1'b0;
        err1_s   = 1'b0;
        start_s  = 1'b0;
        rdata0_s = rdata0_r;
        rdata1_s = rdata1_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    gnt0_s   = ~winner_s;
                    gnt1_s   = winner_s;
                    t_data_s = pick_frame_s;
                    last_s   = winner_s;
                    cnt_s    = 8'd0;
                    if (pick_valid_s) begin
                        start_s = 1'b1;
                    end else begin
                        err0_s = ~winner_s;
                        err1_s = winner_s;
                    end
                end else begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            end
            ST_BUSY: begin
                if (MDIO_DONE) begin
                    done0_s = ~last_r;
                    done1_s = last_r;
                    gnt0_s  = 1'b0;
                    gnt1_s  = 1'b0;
                    if (frame_is_read(t_data_r)) begin
                        if (last_r) begin
                            rdata1_s = RD_DATA;
                        end else begin
                            rdata0_s = RD_DATA;
                        end
                    end else begin
                        rdata0_s = rdata0_r;
                        rdata1_s = rdata1_r;
                    end
                end else if (timeout_hit_s) begin
                    err0_s = ~last_r;
                    err1_s = last_r;
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                    cnt_s  = cnt_inc_s;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_DONE, ST_ERR: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge MDC or negedge RESET) begin
        if (!RESET) begin
            last_r   <= 1'b1;
            cnt_r    <= 8'd0;
            t_data_r <= 32'd0;
            gnt0_r   <= 1'b0;
            gnt1_r   <= 1'b0;
            done0_r  <= 1'b0;
            done1_r  <= 1'b0;
            err0_r   <= 1'b0;
            err1_r   <= 1'b0;
            start_r  <= 1'b0;
            rdata0_r <= 16'd0;
            rdata1_r <= 16'd0;
        end else begin
            last_r   <= last_s;
            cnt_r    <= cnt_s;
            t_data_r <= t_data_s;
            gnt0_r   <= gnt0_s;
            gnt1_r   <= gnt1_s;
            done0_r  <= done0_s;
            done1_r  <= done1_s;
            err0_r   <= err0_s;
            err1_r   <= err1_s;
            start_r  <= start_s;
            rdata0_r <= rdata0_s;
            rdata1_r <= rdata1_s;
        end
    end

    assign GNT0       = gnt0_r;
    assign GNT1       = gnt1_r;
    assign DONE0      = done0_r;
    assign DONE1      = done1_r;
    assign ERR0       = err0_r;
    assign ERR1       = err1_r;
    assign RDATA0     = rdata0_r;
    assign RDATA1     = rdata1_r;
    assign MDIO_START = start_r;
    assign T_DATA     = t_data_r;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed bench for mdio_arbiter: one instance at the default timeout and a
// second at TIMEOUT=10, both sharing stimulus.
module tb_mdio_arbiter;

    logic        MDC = 1'b0;
    logic        RESET = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] frame0 = 32'd0, frame1 = 32'd0;
    logic        mdio_done = 1'b0;
    logic [15:0] rd_data = 16'd0;

    logic        gnt0, gnt1, done0, done1, err0, err1, start;
    logic [15:0] rdata0, rdata1;
    logic [31:0] tdata;
    logic        t_gnt0, t_gnt1, t_done0, t_done1, t_err0, t_err1, t_start;
    logic [15:0] t_rdata0, t_rdata1;
    logic [31:0] t_tdata;

    int checks = 0;
    int errors = 0;

    mdio_arbiter dut (
        .MDC(MDC), .RESET(RESET), .REQ0(req0), .REQ1(req1),
        .FRAME0(frame0), .FRAME1(frame1),
        .GNT0(gnt0), .GNT1(gnt1), .DONE0(done0), .DONE1(done1),
        .ERR0(err0), .ERR1(err1), .RDATA0(rdata0), .RDATA1(rdata1),
        .MDIO_START(start), .T_DATA(tdata),
        .MDIO_DONE(mdio_done), .RD_DATA(rd_data)
    );

    mdio_arbiter #(.TIMEOUT(10)) dut_to (
        .MDC(MDC), .RESET(RESET), .REQ0(req0), .REQ1(req1),
        .FRAME0(frame0), .FRAME1(frame1),
        .GNT0(t_gnt0), .GNT1(t_gnt1), .DONE0(t_done0), .DONE1(t_done1),
        .ERR0(t_err0), .ERR1(t_err1), .RDATA0(t_rdata0), .RDATA1(t_rdata1),
        .MDIO_START(t_start), .T_DATA(t_tdata),
        .MDIO_DONE(mdio_done), .RD_DATA(rd_data)
    );

    always #5 MDC = ~MDC;

    task automatic tick();
        @(posedge MDC);
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b0; req0 = 1'b0; req1 = 1'b0; mdio_done = 1'b0;
        frame0 = 32'd0; frame1 = 32'd0; rd_data = 16'd0;
        tick();
        tick();
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, err0, err1, start, tdata, rdata0, rdata1} !== 71'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {gnt0, gnt1, done0, done1, err0, err1, start, tdata, rdata0, rdata1});
        end
        checks++;
        if ({t_gnt0, t_gnt1, t_done0, t_done1, t_err0, t_err1, t_start, t_tdata, t_rdata0, t_rdata1} !== 71'd0) begin
            errors++; $display("FAIL reset_outputs_to: got %h expected 0", {t_gnt0, t_gnt1, t_done0, t_done1, t_err0, t_err1, t_start, t_tdata, t_rdata0, t_rdata1});
        end
    endtask

    task automatic test_read();
        int starts;
        int gnt_drop;
        apply_reset();
        req0 = 1'b1; frame0 = 32'h6FFFABCD;
        tick();
        checks++; if ({gnt1, gnt0, start} !== 3'b011) begin errors++; $display("FAIL read_grant: got %b expected 011", {gnt1, gnt0, start}); end
        checks++; if (tdata !== 32'h6FFFABCD) begin errors++; $display("FAIL read_tdata: got %h expected 6fffabcd", tdata); end
        frame0 = 32'h00000000;
        starts = 0; gnt_drop = 0;
        for (int i = 1; i < 40; i++) begin
            tick();
            if (start) starts++;
            if (!gnt0 || tdata != 32'h6FFFABCD) gnt_drop++;
        end
        checks++; if (starts !== 0) begin errors++; $display("FAIL read_single_start: got %0d extra starts expected 0", starts); end
        checks++; if (gnt_drop !== 0) begin errors++; $display("FAIL read_hold: got %0d bad cycles expected 0", gnt_drop); end
        mdio_done = 1'b1; rd_data = 16'hDCBA;
        tick();
        mdio_done = 1'b0; req0 = 1'b0; rd_data = 16'h0000;
        checks++; if ({done0, err0, gnt0} !== 3'b100) begin errors++; $display("FAIL read_done: got %b expected 100", {done0, err0, gnt0}); end
        checks++; if (rdata0 !== 16'hDCBA) begin errors++; $display("FAIL read_rdata: got %h expected dcba", rdata0); end
        tick();
        checks++; if ({done0, gnt0} !== 2'b00) begin errors++; $display("FAIL read_done_pulse: got %b expected 00", {done0, gnt0}); end
    endtask

    task automatic test_write();
        apply_reset();
        req1 = 1'b1; frame1 = 32'h6FFF1234;
        tick();
        mdio_done = 1'b1; rd_data = 16'h1111;
        tick();
        mdio_done = 1'b0; req1 = 1'b0;
        checks++; if ({done1, rdata1} !== {1'b1, 16'h1111}) begin errors++; $display("FAIL write_pre_read: got %b/%h expected 1/1111", done1, rdata1); end
        tick();
        req1 = 1'b1; frame1 = 32'h5FFFABCD;
        tick();
        checks++; if ({gnt1, start, tdata} !== {2'b11, 32'h5FFFABCD}) begin errors++; $display("FAIL write_grant: got %b%b/%h expected 11/5fffabcd", gnt1, start, tdata); end
        mdio_done = 1'b1; rd_data = 16'h7777;
        tick();
        mdio_done = 1'b0; req1 = 1'b0;
        checks++; if ({done1, done0, gnt1} !== 3'b100) begin errors++; $display("FAIL write_done: got %b expected 100", {done1, done0, gnt1}); end
        checks++; if (rdata1 !== 16'h1111) begin errors++; $display("FAIL write_rdata_kept: got %h expected 1111", rdata1); end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt;
        logic [1:0] exp_done;
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        frame0 = 32'h5FFF0000; frame1 = 32'h5FFF0001;
        for (int n = 0; n < 4; n++) begin
            exp_gnt = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_done = exp_gnt;
            tick();
            checks++; if ({gnt1, gnt0} !== exp_gnt) begin errors++; $display("FAIL contention_grant%0d: got %b expected %b", n, {gnt1, gnt0}, exp_gnt); end
            mdio_done = 1'b1;
            tick();
            mdio_done = 1'b0;
            checks++; if ({done1, done0} !== exp_done) begin errors++; $display("FAIL contention_done%0d: got %b expected %b", n, {done1, done0}, exp_done); end
            tick();
            checks++; if ({gnt1, gnt0, start} !== 3'b000) begin errors++; $display("FAIL contention_gap%0d: got %b expected 000", n, {gnt1, gnt0, start}); end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_invalid();
        apply_reset();
        req0 = 1'b1; frame0 = 32'h0FFFABCD;
        tick();
        req0 = 1'b0;
        checks++; if ({err0, done0, start, err1} !== 4'b1000) begin errors++; $display("FAIL invalid_err: got %b expected 1000", {err0, done0, start, err1}); end
        tick();
        checks++; if ({err0, gnt0, start} !== 3'b000) begin errors++; $display("FAIL invalid_pulse: got %b expected 000", {err0, gnt0, start}); end
    endtask

    task automatic test_timeout();
        int early;
        apply_reset();
        req0 = 1'b1; frame0 = 32'h6FFF0000;
        tick();
        checks++; if ({t_gnt0, t_start} !== 2'b11) begin errors++; $display("FAIL timeout_grant: got %b expected 11", {t_gnt0, t_start}); end
        req1 = 1'b1; frame1 = 32'h5FFF0042;
        early = 0;
        for (int i = 1; i < 10; i++) begin
            tick();
            if (t_err0 || !t_gnt0) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL timeout_early: got %0d bad cycles expected 0", early); end
        tick();
        req0 = 1'b0;
        checks++; if ({t_err0, t_done0, t_gnt0} !== 3'b100) begin errors++; $display("FAIL timeout_err: got %b expected 100", {t_err0, t_done0, t_gnt0}); end
        checks++; if (t_rdata0 !== 16'h0000) begin errors++; $display("FAIL timeout_rdata: got %h expected 0000", t_rdata0); end
        tick();
        checks++; if ({t_err0, t_gnt1} !== 2'b00) begin errors++; $display("FAIL timeout_gap: got %b expected 00", {t_err0, t_gnt1}); end
        tick();
        checks++; if ({t_gnt1, t_start, t_tdata} !== {2'b11, 32'h5FFF0042}) begin errors++; $display("FAIL timeout_next_grant: got %b%b/%h expected 11/5fff0042", t_gnt1, t_start, t_tdata); end
        mdio_done = 1'b1;
        tick();
        mdio_done = 1'b0; req1 = 1'b0;
        checks++; if ({t_done1, t_err1} !== 2'b10) begin errors++; $display("FAIL timeout_next_done: got %b expected 10", {t_done1, t_err1}); end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req0 = 1'b1; frame0 = 32'h6FFF5555;
        tick();
        tick();
        tick();
        RESET = 1'b0;
        #1;
        checks++; if ({gnt0, gnt1, done0, done1, err0, err1, start, tdata} !== 39'd0) begin errors++; $display("FAIL midreset_clear: got %h expected 0", {gnt0, gnt1, done0, done1, err0, err1, start, tdata}); end
        mdio_done = 1'b1; rd_data = 16'h9999;
        tick();
        RESET = 1'b1; mdio_done = 1'b0;
        checks++; if ({done0, err0, gnt0, rdata0} !== 19'd0) begin errors++; $display("FAIL midreset_quiet: got %h expected 0", {done0, err0, gnt0, rdata0}); end
        tick();
        checks++; if ({gnt0, start, done0, err0} !== 4'b1100) begin errors++; $display("FAIL midreset_regrant: got %b expected 1100", {gnt0, start, done0, err0}); end
        mdio_done = 1'b1; rd_data = 16'h4321;
        tick();
        mdio_done = 1'b0; req0 = 1'b0;
        checks++; if ({done0, rdata0} !== {1'b1, 16'h4321}) begin errors++; $display("FAIL midreset_done: got %b/%h expected 1/4321", done0, rdata0); end
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_invalid();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
